// File: rtl/pb_switch_debouncer.sv
// pb_switch_debouncer: synchronise, debounce and edge-detect board keys/switches.
// Each bit owns a stability counter; db_out flips only after a long steady level.
module pb_switch_debouncer #(
    parameter int                N_BITS        = 4,
    parameter int                STABLE_CYCLES = 1000000,
    parameter int                CNT_W         = 20,
    parameter logic [N_BITS-1:0] RESET_VAL     = '1,
    parameter int                EDGE_SEL      = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_BITS-1:0] raw_in,
    output logic [N_BITS-1:0] db_out,
    output logic [N_BITS-1:0] rise_pulse,
    output logic [N_BITS-1:0] fall_pulse,
    output logic              any_change,
    output logic [N_BITS-1:0] capture,
    input  logic [N_BITS-1:0] capture_clr
);

    // Count value at which the next differing cycle commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_BITS-1:0] sync1;
    logic [N_BITS-1:0] sync2;
    logic [N_BITS-1:0] db_nxt;
    logic [N_BITS-1:0] rise_nxt;
    logic [N_BITS-1:0] fall_nxt;
    logic [N_BITS-1:0] cap_set;

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             db_d;
        logic             rise_d;
        logic             fall_d;
        logic             differ;

        assign differ = sync2[i] != db_out[i];

        // Next count / level: a cnt of zero is the idle state, anything else is counting.
        always_comb begin
            cnt_d  = cnt_q;
            db_d   = db_out[i];
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (differ && (cnt_q == CNT_LAST)) begin
                cnt_d  = '0;
                db_d   = sync2[i];
                rise_d = sync2[i];
                fall_d = ~sync2[i];
            end else if (differ) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end

        // Counter register; a glitch back to db_out restarts from zero.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign db_nxt[i]   = db_d;
        assign rise_nxt[i] = rise_d;
        assign fall_nxt[i] = fall_d;
    end

    // Pick which registered edge feeds the sticky capture flags.
    always_comb begin
        cap_set = rise_pulse | fall_pulse;
        if (EDGE_SEL == 0) begin
            cap_set = rise_pulse;
        end else if (EDGE_SEL == 1) begin
            cap_set = fall_pulse;
        end
    end

    // Output registers; set beats clear so no edge event is lost.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_out     <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
            capture    <= '0;
        end else begin
            db_out     <= db_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
            capture    <= cap_set | (capture & ~capture_clr);
        end
    end

endmodule

// File: tb/tb_pb_switch_debouncer.sv
// tb_pb_switch_debouncer: directed checks of debounce latency, pulses and capture.
// Four-cycle threshold keeps every scenario short.
module tb_pb_switch_debouncer;

    logic       clk_clk;
    logic       reset_reset_n;
    logic [3:0] raw_in;
    logic [3:0] db_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_change;
    logic [3:0] capture;
    logic [3:0] capture_clr;

    int checks = 0;
    int errors = 0;
    logic [3:0] seen;
    int         nfall;

    pb_switch_debouncer #(
        .N_BITS       (4),
        .STABLE_CYCLES(4),
        .CNT_W        (3),
        .RESET_VAL    (4'hF),
        .EDGE_SEL     (1)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .raw_in       (raw_in),
        .db_out       (db_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .any_change   (any_change),
        .capture      (capture),
        .capture_clr  (capture_clr)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    initial begin
        reset_reset_n = 1'b1;
        raw_in        = 4'hF;
        capture_clr   = 4'h0;

        // 1: asynchronous reset mid-cycle
        #12;
        reset_reset_n = 1'b0;
        #1;
        chk("rst_db", db_out, 4'hF);
        chk("rst_rise", rise_pulse, 4'h0);
        chk("rst_fall", fall_pulse, 4'h0);
        chk("rst_any", any_change, 1'b0);
        chk("rst_cap", capture, 4'h0);
        tick(2);
        reset_reset_n = 1'b1;
        seen = 4'h0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            seen = seen | rise_pulse | fall_pulse | {3'b0, any_change};
        end
        chk("idle_pulses", seen, 4'h0);
        chk("idle_db", db_out, 4'hF);

        // 2: clean press on bit 0
        raw_in = 4'hE;
        tick(5);
        chk("press_e5_db", db_out, 4'hF);
        chk("press_e5_fall", fall_pulse, 4'h0);
        tick(1);
        chk("press_e6_db", db_out, 4'hE);
        chk("press_e6_fall", fall_pulse, 4'h1);
        chk("press_e6_rise", rise_pulse, 4'h0);
        chk("press_e6_any", any_change, 1'b1);
        tick(1);
        chk("press_e7_fall", fall_pulse, 4'h0);
        chk("press_e7_any", any_change, 1'b0);
        chk("press_e7_cap", capture, 4'h1);
        tick(3);
        chk("press_cap_hold", capture, 4'h1);

        // release bit 0, then clear capture
        raw_in = 4'hF;
        tick(6);
        chk("rel_db", db_out, 4'hF);
        chk("rel_rise", rise_pulse, 4'h1);
        tick(1);
        chk("rel_cap_kept", capture, 4'h1);
        capture_clr = 4'hF;
        tick(1);
        capture_clr = 4'h0;
        chk("clr_cap", capture, 4'h0);

        // 3: bounce 0,0,0,1 then held low
        nfall = 0;
        raw_in = 4'hE;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (fall_pulse[0]) nfall++;
        end
        raw_in = 4'hF;
        tick(1);
        if (fall_pulse[0]) nfall++;
        raw_in = 4'hE;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (fall_pulse[0]) nfall++;
        end
        chk("bounce_db_hold", db_out, 4'hF);
        chk("bounce_nofall", nfall, 0);
        tick(1);
        chk("bounce_db_flip", db_out, 4'hE);
        chk("bounce_fall", fall_pulse, 4'h1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (fall_pulse[0]) nfall++;
        end
        chk("bounce_one_pulse", nfall, 0);
        chk("bounce_cap", capture, 4'h1);

        // back to idle, clear capture
        raw_in = 4'hF;
        tick(7);
        chk("idle2_db", db_out, 4'hF);
        capture_clr = 4'hF;
        tick(1);
        capture_clr = 4'h0;
        chk("idle2_cap", capture, 4'h0);

        // 4: multi-bit press and release
        raw_in = 4'h5;
        tick(5);
        chk("multi_e5_db", db_out, 4'hF);
        tick(1);
        chk("multi_fall", fall_pulse, 4'hA);
        chk("multi_db", db_out, 4'h5);
        chk("multi_any", any_change, 1'b1);
        tick(1);
        chk("multi_cap", capture, 4'hA);
        raw_in = 4'hF;
        tick(6);
        chk("multi_rise", rise_pulse, 4'hA);
        chk("multi_rise_fall", fall_pulse, 4'h0);
        chk("multi_rel_db", db_out, 4'hF);
        tick(1);
        chk("multi_rise_gone", rise_pulse, 4'h0);
        chk("multi_cap_kept", capture, 4'hA);

        // 5: clear and set on the same edge
        capture_clr = 4'hF;
        tick(1);
        capture_clr = 4'h0;
        raw_in = 4'hE;
        tick(7);
        chk("cs_cap_pending", capture, 4'h1);
        raw_in = 4'hC;
        tick(6);
        chk("cs_fall1", fall_pulse, 4'h2);
        capture_clr = 4'h3;
        tick(1);
        capture_clr = 4'h0;
        chk("cs_cap", capture, 4'h2);
        chk("cs_db", db_out, 4'hC);

        // 6: reset in the middle of counting
        raw_in = 4'h8;
        tick(4);
        chk("mid_db_before", db_out, 4'hC);
        #4;
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_db", db_out, 4'hF);
        chk("mid_rst_fall", fall_pulse, 4'h0);
        chk("mid_rst_cap", capture, 4'h0);
        tick(1);
        reset_reset_n = 1'b1;
        tick(5);
        chk("mid_e5_db", db_out, 4'hF);
        chk("mid_e5_fall", fall_pulse, 4'h0);
        tick(1);
        chk("mid_e6_db", db_out, 4'h8);
        chk("mid_e6_fall", fall_pulse, 4'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
